mem_arbiter: RTL and testbench



---
 rtl/cpu_types_pkg.sv | 13 +
 rtl/dp_types_pkg.sv | 14 +
 rtl/mem_arbiter_if.sv | 39 +++
 rtl/mem_arbiter.sv | 139 +++++++++++++
 tb/tb_mem_arbiter.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU-wide types: RAM handshake state and the machine word.
package cpu_types_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      FREE   = 2'd0,
      BUSY   = 2'd1,
      ACCESS = 2'd2,
      ERROR  = 2'd3
   } ramstate_t;

endpackage

// File: rtl/dp_types_pkg.sv
// Datapath-local types: memory arbiter grant states and default tuning constants.
package dp_types_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      IGRANT = 2'd1,
      DGRANT = 2'd2
   } arb_state_t;

   localparam int unsigned ARB_STARVE_MAX = 4;
   localparam int unsigned ARB_TIMEOUT    = 255;
   localparam int unsigned ARB_TO_W       = 8;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the request/RAM signals around mem_arbiter, for blocks that prefer an interface hookup.
interface mem_arbiter_if
   import cpu_types_pkg::*;
(
   input logic CLK,
   input logic nRST
);

   logic      iREN;
   word_t     iaddr;
   word_t     iload;
   logic      iwait;
   logic      dREN;
   logic      dWEN;
   word_t     daddr;
   word_t     dstore;
   word_t     dload;
   logic      dwait;
   logic      ramREN;
   logic      ramWEN;
   word_t     ramaddr;
   word_t     ramstore;
   word_t     ramload;
   ramstate_t ramstate;
   logic      arb_err;

   modport arb (
      input  CLK, nRST,
      input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
      output iload, iwait, dload, dwait, ramREN, ramWEN, ramaddr, ramstore, arb_err
   );

   modport tb (
      input  CLK, nRST,
      output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
      input  iload, iwait, dload, dwait, ramREN, ramWEN, ramaddr, ramstore, arb_err
   );

endinterface

// File: rtl/mem_arbiter.sv
// Shares the single RAM port between instruction fetch and data access.
// Data has priority; a starvation counter forces fetch through, a timeout aborts hung grants.
module mem_arbiter
   import cpu_types_pkg::*;
   import dp_types_pkg::*;
#(
   parameter int unsigned STARVE_MAX = ARB_STARVE_MAX,
   parameter int unsigned TIMEOUT    = ARB_TIMEOUT,
   parameter int unsigned TO_W       = ARB_TO_W
) (
   input  logic      CLK,
   input  logic      nRST,
   input  logic      iREN,
   input  word_t     iaddr,
   output word_t     iload,
   output logic      iwait,
   input  logic      dREN,
   input  logic      dWEN,
   input  word_t     daddr,
   input  word_t     dstore,
   output word_t     dload,
   output logic      dwait,
   output logic      ramREN,
   output logic      ramWEN,
   output word_t     ramaddr,
   output word_t     ramstore,
   input  word_t     ramload,
   input  ramstate_t ramstate,
   output logic      arb_err
);

   localparam int unsigned SC_W = $clog2(STARVE_MAX + 1);

   arb_state_t      state, next_state;
   logic [SC_W-1:0] starve_cnt;
   logic [TO_W-1:0] to_cnt;

   logic dreq;
   logic starve_full;
   logic to_hit;
   logic ram_done;
   logic ram_err;

   assign dreq        = dREN | dWEN;
   assign starve_full = (starve_cnt == SC_W'(STARVE_MAX));
   assign to_hit      = (to_cnt == TO_W'(TIMEOUT));
   assign ram_done    = (ramstate == ACCESS);
   assign ram_err     = (ramstate == ERROR);

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state      <= IDLE;
         starve_cnt <= '0;
         to_cnt     <= '0;
      end else begin
         state <= next_state;

         // Grants always return through IDLE, so staying put means another waiting cycle.
         if (state != IDLE && next_state == state)
            to_cnt <= to_cnt + 1'b1;
         else
            to_cnt <= '0;

         if (state == IGRANT && ram_done)
            starve_cnt <= '0;
         else if (state == DGRANT && ram_done && iREN && !starve_full)
            starve_cnt <= starve_cnt + 1'b1;
         else if (state == IDLE && !iREN)
            starve_cnt <= '0;
      end
   end

   always_comb begin
      next_state = state;
      ramREN     = 1'b0;
      ramWEN     = 1'b0;
      ramaddr    = '0;
      ramstore   = '0;
      iload      = '0;
      dload      = '0;
      iwait      = 1'b1;
      dwait      = 1'b1;
      arb_err    = 1'b0;

      case (state)
         IDLE: begin
            if (dreq && !(iREN && starve_full))
               next_state = DGRANT;
            else if (iREN)
               next_state = IGRANT;
         end

         DGRANT: begin
            // A dropped request only counts as withdrawn if the RAM has not completed it.
            if (!dreq && !ram_done) begin
               next_state = IDLE;
            end else begin
               ramaddr = daddr;
               if (dWEN) begin
                  ramWEN   = 1'b1;
                  ramstore = dstore;
               end else begin
                  ramREN = 1'b1;
               end

               if (ram_done) begin
                  dwait      = 1'b0;
                  dload      = dWEN ? '0 : ramload;
                  next_state = IDLE;
               end else if (ram_err || to_hit) begin
                  arb_err    = 1'b1;
                  next_state = IDLE;
               end
            end
         end

         IGRANT: begin
            if (!iREN && !ram_done) begin
               next_state = IDLE;
            end else begin
               ramREN  = 1'b1;
               ramaddr = iaddr;

               if (ram_done) begin
                  iwait      = 1'b0;
                  iload      = ramload;
                  next_state = IDLE;
               end else if (ram_err || to_hit) begin
                  arb_err    = 1'b1;
                  next_state = IDLE;
               end
            end
         end

         default: next_state = IDLE;
      endcase
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scoreboard bench for mem_arbiter: stimulus queues expected completions/errors,
// a negedge monitor pops and compares whenever the arbiter signals one.
module tb_mem_arbiter;
   import cpu_types_pkg::*;

   logic      CLK = 1'b0;
   logic      nRST = 1'b0;
   logic      iREN, dREN, dWEN;
   word_t     iaddr, daddr, dstore, ramload;
   word_t     iload, dload, ramaddr, ramstore;
   logic      iwait, dwait, ramREN, ramWEN, arb_err;
   ramstate_t ramstate;

   always #5 CLK = ~CLK;

   mem_arbiter #(
      .STARVE_MAX(4),
      .TIMEOUT   (8),
      .TO_W      (8)
   ) dut (
      .CLK      (CLK),
      .nRST     (nRST),
      .iREN     (iREN),
      .iaddr    (iaddr),
      .iload    (iload),
      .iwait    (iwait),
      .dREN     (dREN),
      .dWEN     (dWEN),
      .daddr    (daddr),
      .dstore   (dstore),
      .dload    (dload),
      .dwait    (dwait),
      .ramREN   (ramREN),
      .ramWEN   (ramWEN),
      .ramaddr  (ramaddr),
      .ramstore (ramstore),
      .ramload  (ramload),
      .ramstate (ramstate),
      .arb_err  (arb_err)
   );

   typedef struct {
      logic  iw;
      logic  dw;
      logic  err;
      word_t il;
      word_t dl;
      logic  rren;
      logic  rwen;
      word_t ra;
      word_t rs;
   } exp_t;

   exp_t        sb[$];
   exp_t        mon_e;
   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endfunction

   function automatic exp_t done_i(word_t ld, word_t addr);
      exp_t e;
      e.iw = 1'b0; e.dw = 1'b1; e.err = 1'b0;
      e.il = ld;   e.dl = '0;
      e.rren = 1'b1; e.rwen = 1'b0; e.ra = addr; e.rs = '0;
      return e;
   endfunction

   function automatic exp_t done_d(word_t ld, word_t addr, logic wr, word_t st);
      exp_t e;
      e.iw = 1'b1; e.dw = 1'b0; e.err = 1'b0;
      e.il = '0;   e.dl = ld;
      e.rren = ~wr; e.rwen = wr; e.ra = addr; e.rs = wr ? st : '0;
      return e;
   endfunction

   function automatic exp_t err_d(word_t addr);
      exp_t e;
      e.iw = 1'b1; e.dw = 1'b1; e.err = 1'b1;
      e.il = '0;   e.dl = '0;
      e.rren = 1'b1; e.rwen = 1'b0; e.ra = addr; e.rs = '0;
      return e;
   endfunction

   always @(negedge CLK) begin
      if (nRST && (iwait === 1'b0 || dwait === 1'b0 || arb_err === 1'b1)) begin
         if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_event: got iwait=%b dwait=%b arb_err=%b, expected no event",
                     iwait, dwait, arb_err);
         end else begin
            mon_e = sb.pop_front();
            check("mon_iwait",    iwait,    mon_e.iw);
            check("mon_dwait",    dwait,    mon_e.dw);
            check("mon_arb_err",  arb_err,  mon_e.err);
            check("mon_iload",    iload,    mon_e.il);
            check("mon_dload",    dload,    mon_e.dl);
            check("mon_ramREN",   ramREN,   mon_e.rren);
            check("mon_ramWEN",   ramWEN,   mon_e.rwen);
            check("mon_ramaddr",  ramaddr,  mon_e.ra);
            check("mon_ramstore", ramstore, mon_e.rs);
         end
      end else if (sb.size() != 0) begin
         mon_e = sb.pop_front();
         n_tests++;
         n_fail++;
         $display("FAIL missing_event: got iwait=%b dwait=%b arb_err=%b, expected iwait=%b dwait=%b arb_err=%b",
                  iwait, dwait, arb_err, mon_e.iw, mon_e.dw, mon_e.err);
      end
   end

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle_all();
      iREN     = 1'b0;
      dREN     = 1'b0;
      dWEN     = 1'b0;
      ramstate = FREE;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, expected $finish earlier", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      idle_all();
      iaddr   = '0;
      daddr   = '0;
      dstore  = '0;
      ramload = '0;

      // Reset values
      #2;
      check("rst_ramREN",   ramREN,   1'b0);
      check("rst_ramWEN",   ramWEN,   1'b0);
      check("rst_ramaddr",  ramaddr,  32'h0);
      check("rst_ramstore", ramstore, 32'h0);
      check("rst_iload",    iload,    32'h0);
      check("rst_dload",    dload,    32'h0);
      check("rst_iwait",    iwait,    1'b1);
      check("rst_dwait",    dwait,    1'b1);
      check("rst_arb_err",  arb_err,  1'b0);
      #10 nRST = 1'b1;
      step();

      // Reset asserted mid data write
      dWEN = 1'b1; daddr = 32'h800; dstore = 32'h11; ramstate = BUSY;
      step();
      check("rstmid_ramWEN_before", ramWEN, 1'b1);
      #2 nRST = 1'b0;
      #1;
      check("rstmid_ramWEN_async", ramWEN,  1'b0);
      check("rstmid_dwait",        dwait,   1'b1);
      check("rstmid_iwait",        iwait,   1'b1);
      check("rstmid_ramaddr",      ramaddr, 32'h0);
      idle_all();
      step();
      nRST = 1'b1;
      step();
      check("rstmid_after_ramWEN", ramWEN, 1'b0);
      check("rstmid_after_ramREN", ramREN, 1'b0);

      // Instruction fetch, ACCESS on second grant cycle
      iREN = 1'b1; iaddr = 32'h40; ramstate = BUSY;
      check("ifetch_idle_ramREN", ramREN, 1'b0);
      step();
      check("ifetch_g1_ramREN",  ramREN,  1'b1);
      check("ifetch_g1_ramaddr", ramaddr, 32'h40);
      check("ifetch_g1_iwait",   iwait,   1'b1);
      step();
      ramstate = ACCESS; ramload = 32'h2108000A;
      sb.push_back(done_i(32'h2108000A, 32'h40));
      step();
      idle_all();
      check("ifetch_one_cycle_iwait", iwait, 1'b1);
      step();

      // Simultaneous requests: data first, one IDLE gap, then instruction
      iREN = 1'b1; iaddr = 32'h44; dREN = 1'b1; daddr = 32'h100; ramstate = BUSY;
      step();
      check("both_dgrant_ramaddr", ramaddr, 32'h100);
      check("both_dgrant_ramREN",  ramREN,  1'b1);
      check("both_dgrant_iwait",   iwait,   1'b1);
      ramstate = ACCESS; ramload = 32'h12345678;
      sb.push_back(done_d(32'h12345678, 32'h100, 1'b0, 32'h0));
      step();
      dREN = 1'b0; ramstate = BUSY;
      check("both_gap_ramREN", ramREN, 1'b0);
      step();
      check("both_igrant_ramaddr", ramaddr, 32'h44);
      ramstate = ACCESS; ramload = 32'hCAFEF00D;
      sb.push_back(done_i(32'hCAFEF00D, 32'h44));
      step();
      idle_all();
      step();

      // Starvation: four writes, a forced fetch, then data resumes
      iREN = 1'b1; iaddr = 32'h80; dWEN = 1'b1; daddr = 32'h200;
      ramstate = ACCESS; ramload = 32'hFFFF0000;
      for (int w = 0; w < 4; w++) begin
         dstore = 32'h1000 + 32'(w);
         step();
         sb.push_back(done_d(32'h0, 32'h200, 1'b1, 32'h1000 + 32'(w)));
         step();
      end
      step();
      check("starve_forced_ramaddr", ramaddr, 32'h80);
      sb.push_back(done_i(32'hFFFF0000, 32'h80));
      step();
      dstore = 32'h2000;
      step();
      check("starve_resume_ramaddr", ramaddr, 32'h200);
      sb.push_back(done_d(32'h0, 32'h200, 1'b1, 32'h2000));
      step();
      idle_all();
      step();

      // Read+write together: write wins
      dREN = 1'b1; dWEN = 1'b1; daddr = 32'h300; dstore = 32'hDEADBEEF;
      ramload = 32'h77777777; ramstate = BUSY;
      step();
      check("rw_ramWEN",   ramWEN,   1'b1);
      check("rw_ramREN",   ramREN,   1'b0);
      check("rw_ramstore", ramstore, 32'hDEADBEEF);
      ramstate = ACCESS;
      sb.push_back(done_d(32'h0, 32'h300, 1'b1, 32'hDEADBEEF));
      step();
      idle_all();
      step();

      // Timeout: BUSY forever, abort in the ninth grant cycle
      dREN = 1'b1; daddr = 32'h400; ramstate = BUSY;
      for (int g = 1; g <= 8; g++) begin
         step();
         check($sformatf("to_g%0d_arb_err", g), arb_err, 1'b0);
         check($sformatf("to_g%0d_dwait", g),   dwait,   1'b1);
      end
      step();
      sb.push_back(err_d(32'h400));
      step();
      idle_all();
      check("to_back_idle_ramREN", ramREN, 1'b0);
      step();

      // ERROR from RAM: immediate abort
      dREN = 1'b1; daddr = 32'h500; ramstate = ERROR;
      step();
      sb.push_back(err_d(32'h500));
      step();
      idle_all();
      check("err_back_idle_ramREN", ramREN, 1'b0);
      step();

      // Withdrawal before ACCESS
      iREN = 1'b1; iaddr = 32'h600; ramstate = BUSY;
      step();
      check("wd_granted_ramREN", ramREN, 1'b1);
      iREN = 1'b0;
      #1;
      check("wd_same_cycle_ramREN",  ramREN,  1'b0);
      check("wd_same_cycle_ramaddr", ramaddr, 32'h0);
      step();
      check("wd_next_ramREN", ramREN, 1'b0);
      idle_all();
      step();

      // Drop and ACCESS in the same cycle: completion wins
      iREN = 1'b1; iaddr = 32'h700; ramstate = BUSY;
      step();
      iREN = 1'b0; ramstate = ACCESS; ramload = 32'h55AA55AA;
      sb.push_back(done_i(32'h55AA55AA, 32'h700));
      step();
      idle_all();
      step();

      step();
      check("sb_drained", sb.size(), 32'h0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
